seven_seg_scan_mux: RTL and testbench
=====================================

Name: seven_seg_scan_mux

Overview:
- Time-multiplexed scan driver for a 4-digit common-anode seven-segment display.
- Captures a 16-bit display value and walks through its four hex nibbles.
- Feeds each nibble to the downstream hex-to-segment decoder (4-bit D input) and drives the matching active-low anode enable and decimal point.
- Inserts a blank gap between digits to suppress ghosting; sits between the MIPS debug/PC display source and the decoder.

Parameters:
- PRESCALE, 50000: clk cycles each digit is driven (DRIVE slot length); legal 1..65535.
- GAP_CYCLES, 500: clk cycles of all-anodes-off between digits; legal 0..65535; 0 removes the GAP state.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  scan enable; 0 holds the scan and blanks the display.
- load  input  1  capture strobe for value_in/dp_in.
- value_in  input  16  hex value; nibble k goes to digit k, where digit 0 is rightmost.
- dp_in  input  4  decimal point request per digit, active-high.
- D  output  4  nibble to the decoder D input.
- AN  output  4  anode enables, active-low; AN[k] selects digit k.
- DP  output  1  decimal point segment, active-low.
- frame_done  output  1  one-cycle pulse at the end of digit 3's DRIVE slot.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- All outputs are registered.
- Reset values:
  - value_q = 0, dp_q = 0, idx = 0, cnt = 0, state = GAP.
  - D = 4'h0, AN = 4'b1111, DP = 1, frame_done = 0.
- Capture:
  - When load = 1 at a rising edge, value_q <= value_in and dp_q <= dp_in. This is independent of en and state.
  - The new value is sampled only on entry to the next DRIVE slot. The digit currently displayed never changes mid-slot.
- FSM states: GAP, DRIVE.
- GAP:
  - AN = 1111, DP = 1; cnt counts 0..GAP_CYCLES-1.
  - When cnt reaches GAP_CYCLES-1: go to DRIVE, cnt <= 0, and on the same edge load D <= value_q[4*idx+3 : 4*idx], AN <= ~(1<<idx), DP <= ~dp_q[idx].
- DRIVE:
  - Holds D/AN/DP constant; cnt counts 0..PRESCALE-1.
  - At the last count: idx <= idx+1 mod 4 (3 wraps to 0) and cnt <= 0.
  - If GAP_CYCLES > 0: go to GAP, and AN <= 1111, DP <= 1 on the same edge.
  - If GAP_CYCLES = 0: stay in DRIVE and load the next digit directly.
- frame_done: asserted for exactly one cycle on the edge that ends digit 3's DRIVE slot.
- Timing:
  - Full frame = 4*(PRESCALE+GAP_CYCLES) cycles.
  - After reset release, AN stays 1111 for GAP_CYCLES cycles; then digit 0 is lit.
- Enable:
  - en = 0: on the next edge go to GAP, cnt <= 0, AN <= 1111, DP <= 1, frame_done <= 0; idx is held.
  - en = 1 again: resume with a full GAP, then DRIVE of the held idx.
- Simultaneous events:
  - load on the same edge as DRIVE entry: the new value is not used for that digit (D is loaded from the old value_q). It is used from the following slot onward.
  - en = 0 on the last DRIVE count: idx does not advance and frame_done does not pulse.
- Reset mid-scan returns immediately to reset values, regardless of state.
- Counter width is 16 bits. Parameters outside the legal range are unsupported.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - On DRIVE entry for digit k ≥ 1, AN stays 1111 and DP = ~dp_q[k] is still driven if value_q[15 : 4k] == 0.
  - The slot still consumes PRESCALE cycles, so frame timing is unchanged.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: all four digits are always lit.

Test Plan:
- Reset: PRESCALE=4, GAP=1; reset pulse mid-DRIVE of digit 2 -> outputs go to reset values immediately. After release: AN=1111 for 1 cycle, then AN=1110 with D=value_q[3:0] for 4 cycles.
- Scan order and timing: load value 16'hA3C5, dp_in 4'b0100 -> per frame:
  - AN=1110 with D=5, then 1101/C, 1011/3 with DP=0, then 0111/A.
  - AN=1111 for 1 cycle between digits.
  - frame_done pulses once every 20 cycles.
- Mid-slot load: load 16'h1234 during the digit-1 DRIVE slot of 16'hA3C5 -> D stays C for that slot; the next slot shows D=2.
- GAP_CYCLES=0, PRESCALE=2: AN sequence 1110, 1110, 1101, 1101, ... with no 1111 cycles; frame = 8 cycles.
- Enable: drop en during the digit-2 DRIVE slot for 10 cycles -> AN=1111 and no frame_done. On resume: 1 GAP cycle, then digit 2 driven for 4 cycles.
- Leading-zero blank (macro defined): value 16'h0070 -> digit 3 and 2 slots show AN=1111, digit 1 shows D=7, digit 0 shows D=0. Value 16'h0000 -> only digit 0 is lit.

Source files
------------

// File: rtl/seven_seg_scan_mux.sv
// Scan driver for a 4-digit common-anode seven-segment display with a blank gap between digits.
// Optional macro SEVEN_SEG_LEADING_ZERO_BLANK_EN: leading-zero digits (never digit 0) stay dark.
module seven_seg_scan_mux #(
    parameter int PRESCALE   = 50000,
    parameter int GAP_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    output logic [3:0]  D,
    output logic [3:0]  AN,
    output logic        DP,
    output logic        frame_done
);
    typedef enum logic {GAP = 1'b0, DRIVE = 1'b1} state_t;

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic        GAP_NONE = (GAP_CYCLES == 0);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] value_q;
    logic [3:0]  dp_q;
    logic [3:0]  d_q, d_d;
    logic [3:0]  an_q, an_d;
    logic        dpo_q, dpo_d;
    logic        fd_q, fd_d;

    logic [1:0]  ld_idx_s;
    logic        blank_s;
    logic [3:0]  ld_d_s;
    logic [3:0]  ld_an_s;
    logic        ld_dp_s;

    function automatic logic [3:0] nibble_sel(input logic [15:0] v, input logic [1:0] k);
        logic [3:0] n;
        case (k)
            2'd0:    n = v[3:0];
            2'd1:    n = v[7:4];
            2'd2:    n = v[11:8];
            2'd3:    n = v[15:12];
            default: n = 4'h0;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] anode_sel(input logic [1:0] k);
        logic [3:0] a;
        case (k)
            2'd0:    a = 4'b1110;
            2'd1:    a = 4'b1101;
            2'd2:    a = 4'b1011;
            2'd3:    a = 4'b0111;
            default: a = 4'b1111;
        endcase
        return a;
    endfunction

    // Digit about to be loaded: current idx when leaving GAP, the next one when chaining DRIVE slots.
    always_comb begin
        ld_idx_s = (state_q == DRIVE) ? (idx_q + 2'd1) : idx_q;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        case (ld_idx_s)
            2'd1:    blank_s = (value_q[15:4] == 12'h000);
            2'd2:    blank_s = (value_q[15:8] == 8'h00);
            2'd3:    blank_s = (value_q[15:12] == 4'h0);
            default: blank_s = 1'b0;
        endcase
`else
        blank_s = 1'b0;
`endif
        ld_d_s  = nibble_sel(value_q, ld_idx_s);
        ld_an_s = blank_s ? 4'b1111 : anode_sel(ld_idx_s);
        ld_dp_s = ~dp_q[ld_idx_s];
    end

    // Scan FSM next-state and registered-output next values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        d_d     = d_q;
        an_d    = an_q;
        dpo_d   = dpo_q;
        fd_d    = 1'b0;
        if (!en) begin
            state_d = GAP;
            cnt_d   = 16'd0;
            an_d    = 4'b1111;
            dpo_d   = 1'b1;
        end else begin
            case (state_q)
                GAP: begin
                    if (GAP_NONE || (cnt_q == GAP_LAST)) begin
                        state_d = DRIVE;
                        cnt_d   = 16'd0;
                        d_d     = ld_d_s;
                        an_d    = ld_an_s;
                        dpo_d   = ld_dp_s;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                DRIVE: begin
                    if (cnt_q == PRE_LAST) begin
                        idx_d = idx_q + 2'd1;
                        cnt_d = 16'd0;
                        fd_d  = (idx_q == 2'd3);
                        if (GAP_NONE) begin
                            d_d   = ld_d_s;
                            an_d  = ld_an_s;
                            dpo_d = ld_dp_s;
                        end else begin
                            state_d = GAP;
                            an_d    = 4'b1111;
                            dpo_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = GAP;
                    cnt_d   = 16'd0;
                    an_d    = 4'b1111;
                    dpo_d   = 1'b1;
                end
            endcase
        end
    end

    // Scan state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= GAP;
            cnt_q   <= 16'd0;
            idx_q   <= 2'd0;
            d_q     <= 4'h0;
            an_q    <= 4'b1111;
            dpo_q   <= 1'b1;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            d_q     <= d_d;
            an_q    <= an_d;
            dpo_q   <= dpo_d;
            fd_q    <= fd_d;
        end
    end

    // Display value capture; read only at DRIVE entry so a lit digit never changes mid-slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= 16'h0000;
            dp_q    <= 4'h0;
        end else if (load) begin
            value_q <= value_in;
            dp_q    <= dp_in;
        end else begin
            value_q <= value_q;
            dp_q    <= dp_q;
        end
    end

    assign D          = d_q;
    assign AN         = an_q;
    assign DP         = dpo_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Directed bench for seven_seg_scan_mux: PRESCALE=4/GAP=1 instance plus PRESCALE=2/GAP=0 instance.
module tb_seven_seg_scan_mux;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  d0, an0, d1, an1;
    logic        dp0, fd0, dp1, fd1;
    int          n_pass = 0;
    int          n_total = 0;
    logic [3:0]  lz_an2, lz_an3, lz_an1z;

    always #5 clk = ~clk;

    seven_seg_scan_mux #(.PRESCALE(4), .GAP_CYCLES(1)) u0 (
        .clk(clk), .reset(reset), .en(en), .load(load), .value_in(value_in), .dp_in(dp_in),
        .D(d0), .AN(an0), .DP(dp0), .frame_done(fd0)
    );

    seven_seg_scan_mux #(.PRESCALE(2), .GAP_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .en(en), .load(load), .value_in(value_in), .dp_in(dp_in),
        .D(d1), .AN(an1), .DP(dp1), .frame_done(fd1)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input string tag, input logic [3:0] an, input logic [3:0] d,
                        input logic dp, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_an"}, an0, an);
            chk({tag, "_d"}, d0, d);
            chk({tag, "_dp"}, {3'b000, dp0}, {3'b000, dp});
            chk({tag, "_fd"}, {3'b000, fd0}, 4'b0000);
        end
    endtask

    task automatic gap(input string tag, input logic fd);
        tick();
        chk({tag, "_an"}, an0, 4'b1111);
        chk({tag, "_dp"}, {3'b000, dp0}, 4'b0001);
        chk({tag, "_fd"}, {3'b000, fd0}, {3'b000, fd});
    endtask

    task automatic u1_step(input logic [3:0] an, input logic [3:0] d, input logic dp,
                           input logic fd);
        tick();
        chk("g0_an", an1, an);
        chk("g0_d", d1, d);
        chk("g0_dp", {3'b000, dp1}, {3'b000, dp});
        chk("g0_fd", {3'b000, fd1}, {3'b000, fd});
    endtask

    initial begin
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        lz_an2 = 4'b1111; lz_an3 = 4'b1111; lz_an1z = 4'b1111;
`else
        lz_an2 = 4'b1011; lz_an3 = 4'b0111; lz_an1z = 4'b1101;
`endif
        reset = 1'b1; en = 1'b1; load = 1'b0; value_in = 16'h0000; dp_in = 4'h0;
        #12;
        chk("rst_an", an0, 4'b1111);
        chk("rst_d", d0, 4'h0);
        chk("rst_dp", {3'b000, dp0}, 4'b0001);
        chk("rst_fd", {3'b000, fd0}, 4'b0000);

        // Load lands on the same edge as the first DRIVE entry: digit 0 uses the old (zero) value.
        value_in = 16'hA3C5; dp_in = 4'b0100; load = 1'b1;
        reset = 1'b0;
        #1;
        chk("start_gap_an", an0, 4'b1111);
        slot("ld_same_edge", 4'b1110, 4'h0, 1'b1, 1);
        load = 1'b0;
        slot("f1_dig0", 4'b1110, 4'h0, 1'b1, 3);
        gap("f1_gap0", 1'b0);
        slot("f1_dig1", 4'b1101, 4'hC, 1'b1, 4);
        gap("f1_gap1", 1'b0);
        slot("f1_dig2", 4'b1011, 4'h3, 1'b0, 4);
        gap("f1_gap2", 1'b0);
        slot("f1_dig3", 4'b0111, 4'hA, 1'b1, 4);
        gap("f1_end", 1'b1);

        slot("f2_dig0", 4'b1110, 4'h5, 1'b1, 4);
        gap("f2_gap0", 1'b0);
        // Mid-slot load during digit 1 keeps C on screen until the slot ends.
        slot("f2_dig1a", 4'b1101, 4'hC, 1'b1, 1);
        value_in = 16'h1234; load = 1'b1;
        slot("midload", 4'b1101, 4'hC, 1'b1, 1);
        load = 1'b0;
        slot("f2_dig1b", 4'b1101, 4'hC, 1'b1, 2);
        gap("f2_gap1", 1'b0);
        slot("newval_dig2", 4'b1011, 4'h2, 1'b0, 4);
        gap("f2_gap2", 1'b0);
        slot("newval_dig3", 4'b0111, 4'h1, 1'b1, 4);
        gap("f2_end", 1'b1);

        slot("f3_dig0", 4'b1110, 4'h4, 1'b1, 4);
        gap("f3_gap0", 1'b0);
        slot("f3_dig1", 4'b1101, 4'h3, 1'b1, 4);
        gap("f3_gap1", 1'b0);
        slot("f3_dig2a", 4'b1011, 4'h2, 1'b0, 2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) gap("en_off", 1'b0);
        en = 1'b1;
        slot("resume_dig2", 4'b1011, 4'h2, 1'b0, 4);
        gap("resume_gap", 1'b0);
        slot("f3_dig3a", 4'b0111, 4'h1, 1'b1, 3);
        // Dropping en on digit 3's last count: no advance, no frame_done.
        en = 1'b0;
        gap("en_last_cnt", 1'b0);
        gap("en_last_hold", 1'b0);
        en = 1'b1;
        slot("held_dig3", 4'b0111, 4'h1, 1'b1, 4);
        gap("held_end", 1'b1);
        slot("f4_dig0", 4'b1110, 4'h4, 1'b1, 4);
        gap("f4_gap0", 1'b0);
        slot("f4_dig1", 4'b1101, 4'h3, 1'b1, 4);
        gap("f4_gap1", 1'b0);
        slot("f4_dig2", 4'b1011, 4'h2, 1'b0, 2);

        // Asynchronous reset in the middle of digit 2's slot.
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_an", an0, 4'b1111);
        chk("mid_rst_d", d0, 4'h0);
        chk("mid_rst_dp", {3'b000, dp0}, 4'b0001);
        chk("mid_rst_fd", {3'b000, fd0}, 4'b0000);
        #2 reset = 1'b0;
        #1;
        chk("post_rst_gap", an0, 4'b1111);
        slot("post_rst_dig0", 4'b1110, 4'h0, 1'b1, 4);
        gap("post_rst_gap0", 1'b0);
        slot("post_rst_dig1", 4'b1101, 4'h0, 1'b1, 1);

        // Zero-gap instance: digits chained back to back, 8-cycle frame.
        reset = 1'b1; value_in = 16'hA3C5; dp_in = 4'b0100; load = 1'b1;
        #4 reset = 1'b0;
        u1_step(4'b1110, 4'h0, 1'b1, 1'b0);
        load = 1'b0;
        u1_step(4'b1110, 4'h0, 1'b1, 1'b0);
        for (int f = 0; f < 2; f++) begin
            u1_step(4'b1101, 4'hC, 1'b1, 1'b0);
            u1_step(4'b1101, 4'hC, 1'b1, 1'b0);
            u1_step(4'b1011, 4'h3, 1'b0, 1'b0);
            u1_step(4'b1011, 4'h3, 1'b0, 1'b0);
            u1_step(4'b0111, 4'hA, 1'b1, 1'b0);
            u1_step(4'b0111, 4'hA, 1'b1, 1'b0);
            u1_step(4'b1110, 4'h5, 1'b1, 1'b1);
            u1_step(4'b1110, 4'h5, 1'b1, 1'b0);
        end

        // Leading-zero value 0070, then 0000.
        reset = 1'b1; value_in = 16'h0070; dp_in = 4'b0000; load = 1'b1;
        #4 reset = 1'b0;
        slot("lz_dig0a", 4'b1110, 4'h0, 1'b1, 1);
        load = 1'b0;
        slot("lz_dig0b", 4'b1110, 4'h0, 1'b1, 3);
        gap("lz_gap0", 1'b0);
        slot("lz_dig1", 4'b1101, 4'h7, 1'b1, 4);
        gap("lz_gap1", 1'b0);
        slot("lz_dig2", lz_an2, 4'h0, 1'b1, 4);
        gap("lz_gap2", 1'b0);
        slot("lz_dig3", lz_an3, 4'h0, 1'b1, 4);
        gap("lz_end", 1'b1);
        value_in = 16'h0000; load = 1'b1;
        slot("z_dig0a", 4'b1110, 4'h0, 1'b1, 1);
        load = 1'b0;
        slot("z_dig0b", 4'b1110, 4'h0, 1'b1, 3);
        gap("z_gap0", 1'b0);
        slot("z_dig1", lz_an1z, 4'h0, 1'b1, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
